// File: rtl/four_input_xor_gate_a_if.sv
// Bus bundle for four_input_xor_gate_a: input nibble a..d plus the parity,
// edge-pulse and odd-cycle counter outputs.
interface four_input_xor_gate_a_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic             e_q;
    logic             e_rise;
    logic             e_fall;
    logic [CNT_W-1:0] odd_cnt;
    logic             odd_cnt_sat;

    modport master (
        output a, b, c, d,
        input  e, e_q, e_rise, e_fall, odd_cnt, odd_cnt_sat
    );

    modport slave (
        input  a, b, c, d,
        output e, e_q, e_rise, e_fall, odd_cnt, odd_cnt_sat
    );
endinterface

// File: rtl/four_input_xor_gate_a.sv
// Four-input odd-parity gate with registered parity, edge pulses and a saturating
// odd-cycle counter; the counter exists only when FOUR_INPUT_XOR_GATE_A_CNT_EN is defined.
module four_input_xor_gate_a #(
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    four_input_xor_gate_a_if.slave    bus
);
    logic parity;

    logic e_q_q,    e_q_d;
    logic e_prev_q, e_prev_d;
    logic e_rise_q, e_rise_d;
    logic e_fall_q, e_fall_d;

    // Pure XOR tree; reset never touches it.
    assign parity = bus.a ^ bus.b ^ bus.c ^ bus.d;
    assign bus.e  = parity;

    // e_prev_q holds e_q from one edge earlier, so the pulses land the cycle after e_q moves.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        e_q_d    = parity;
        e_prev_d = e_q_q;
        e_rise_d = e_q_q & ~e_prev_q;
        e_fall_d = ~e_q_q & e_prev_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (rst) begin
            e_q_q    <= 1'b0;
            e_prev_q <= 1'b0;
            e_rise_q <= 1'b0;
            e_fall_q <= 1'b0;
        end else begin
            e_q_q    <= e_q_d;
            e_prev_q <= e_prev_d;
            e_rise_q <= e_rise_d;
            e_fall_q <= e_fall_d;
        end
    end

    assign bus.e_q    = e_q_q;
    assign bus.e_rise = e_rise_q;
    assign bus.e_fall = e_fall_q;

`ifdef FOUR_INPUT_XOR_GATE_A_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;

    // Saturate rather than wrap at all-ones.
    always_comb begin
        odd_cnt_d = odd_cnt_q;
        if (parity && (odd_cnt_q != CNT_MAX)) begin
            odd_cnt_d = odd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            odd_cnt_q <= {CNT_W{1'b0}};
        end else begin
            odd_cnt_q <= odd_cnt_d;
        end
    end

    assign bus.odd_cnt     = odd_cnt_q;
    assign bus.odd_cnt_sat = (odd_cnt_q == CNT_MAX);
`else
    assign bus.odd_cnt     = {CNT_W{1'b0}};
    assign bus.odd_cnt_sat = 1'b0;
`endif

endmodule

// File: tb/tb_four_input_xor_gate_a.sv
// Scoreboard bench for four_input_xor_gate_a: one 16-bit and one 2-bit counter
// instance share directed stimulus; a monitor checks registered outputs each cycle.
module tb_four_input_xor_gate_a;
`ifdef FOUR_INPUT_XOR_GATE_A_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic [3:0]  nib;
        logic        glitch;
        logic        eq;
        logic        rise;
        logic        fall;
        logic [15:0] c16;
        logic [1:0]  c2;
    } vec_t;

    typedef struct packed {
        logic        eq;
        logic        rise;
        logic        fall;
        logic [15:0] c16;
        logic        sat16;
        logic [1:0]  c2;
        logic        sat2;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[$];
    exp_t sb[$];
    logic [15:0] par_tbl;

    four_input_xor_gate_a_if #(.CNT_W(16)) bus16 ();
    four_input_xor_gate_a_if #(.CNT_W(2))  bus2 ();

    four_input_xor_gate_a #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    four_input_xor_gate_a #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_nib(input logic [3:0] n);
        {bus16.a, bus16.b, bus16.c, bus16.d} = n;
        {bus2.a,  bus2.b,  bus2.c,  bus2.d}  = n;
    endtask

    task automatic add(input logic r, input logic [3:0] n, input logic g, input logic eq,
                       input logic rise, input logic fall, input logic [15:0] c16,
                       input logic [1:0] c2);
        vecs.push_back('{rst: r, nib: n, glitch: g, eq: eq, rise: rise, fall: fall,
                         c16: c16, c2: c2});
    endtask

    // Monitor: one expected entry is queued before each edge it applies to.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("e_q16",    32'(bus16.e_q),         32'(x.eq));
                check("e_rise16", 32'(bus16.e_rise),      32'(x.rise));
                check("e_fall16", 32'(bus16.e_fall),      32'(x.fall));
                check("cnt16",    32'(bus16.odd_cnt),     32'(x.c16));
                check("sat16",    32'(bus16.odd_cnt_sat), 32'(x.sat16));
                check("e_q2",     32'(bus2.e_q),          32'(x.eq));
                check("e_rise2",  32'(bus2.e_rise),       32'(x.rise));
                check("e_fall2",  32'(bus2.e_fall),       32'(x.fall));
                check("cnt2",     32'(bus2.odd_cnt),      32'(x.c2));
                check("sat2",     32'(bus2.odd_cnt_sat),  32'(x.sat2));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t x;
        checks   = 0;
        failures = 0;
        par_tbl  = 16'h6996;
        rst      = 1'b1;
        set_nib(4'h0);

        // Comb sweep under reset: d every 2 ns, c every 4, b every 8, a every 16.
        for (int i = 0; i < 16; i++) begin
            set_nib(4'(i));
            #1;
            check("e_sweep16", 32'(bus16.e), 32'(par_tbl[i]));
            check("e_sweep2",  32'(bus2.e),  32'(par_tbl[i]));
            #1;
        end

        //   rst  nib   glt  eq   rise fall c16     c2
        add(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
        add(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
        add(1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 2'd1);
        add(1'b0, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 2'd2);
        add(1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 2'd3);
        add(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
        add(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 2'd1);
        add(1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 2'd2);
        add(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 2'd3);
        add(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 2'd3);
        add(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 2'd3);
        add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 2'd3);
        add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 2'd3);
        add(1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 2'd3);
        add(1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 2'd3);
        add(1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6, 2'd3);
        add(1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 16'd7, 2'd3);
        add(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0);

        foreach (vecs[k]) begin
            v = vecs[k];
            @(negedge clk);
            rst = v.rst;
            set_nib(v.nib);
            x.eq    = v.eq;
            x.rise  = v.rise;
            x.fall  = v.fall;
            x.c16   = CNT_EN ? v.c16 : 16'd0;
            x.sat16 = 1'b0;
            x.c2    = CNT_EN ? v.c2 : 2'd0;
            x.sat2  = CNT_EN && (v.c2 == 2'd3);
            sb.push_back(x);
            #1;
            check("e_step16", 32'(bus16.e), 32'(par_tbl[v.nib]));
            check("e_step2",  32'(bus2.e),  32'(par_tbl[v.nib]));
            if (v.glitch) begin
                #1;
                bus16.d = ~bus16.d;
                bus2.d  = ~bus2.d;
                #1;
                bus16.d = ~bus16.d;
                bus2.d  = ~bus2.d;
            end
        end

        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
